// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// The opcode is the top OPC_W bits of an instruction word.
package fetch_sequencer_pkg;

  localparam int DATA_W_DEF = 20;
  localparam int ADDR_W_DEF = 5;
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, instruction memory port and decode-side outputs.
// master = sequencer side, slave = memory/decode/execute environment.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic              stall;
  logic              branch;
  logic              zero;
  logic [ADDR_W-1:0] br_pc;
  logic [DATA_W-1:0] imm;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] ins;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_valid;
  logic              flush;
  logic              halted;
  logic              fault;

  modport master (
    input  start, stall, branch, zero, br_pc, imm, imem_data,
    output imem_en, imem_addr, ins, ins_pc, ins_valid, flush, halted, fault
  );

  modport slave (
    output start, stall, branch, zero, br_pc, imm, imem_data,
    input  imem_en, imem_addr, ins, ins_pc, ins_valid, flush, halted, fault
  );
endinterface

// File: rtl/fetch_sequencer_branch_target_calc.sv
// Branch target = br_pc + 1 + imm in DATA_W two's complement, with range check
// against the populated part of instruction memory.
module branch_target_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = 20
) (
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              out_of_range_o
);
  logic [DATA_W-1:0] sum;

  assign sum            = DATA_W'(br_pc_i) + DATA_W'(1) + imm_i;
  assign target_o       = sum[ADDR_W-1:0];
  // Sign bit set means the target is negative.
  assign out_of_range_o = sum[DATA_W-1] | (sum >= DATA_W'(MEM_DEPTH));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives a 1-cycle-latency instruction
// memory and registers returned words for decode, with stall, branch flush and HALT.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               DATA_W      = DATA_W_DEF,
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               MEM_DEPTH   = 20,
  parameter int               RESET_PC    = 0,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  // One extra bit so pc can sit at MEM_DEPTH without wrapping.
  localparam int                PC_W       = ADDR_W + 1;
  localparam logic [PC_W-1:0]   DEPTH_PC   = PC_W'(MEM_DEPTH);
  localparam logic [PC_W-1:0]   RESET_PCW  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]   RESET_NEXT = PC_W'(RESET_PC + 1);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  fs_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_valid_q, req_valid_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              ins_valid_q, ins_valid_d;

  logic [ADDR_W-1:0] target;
  logic [PC_W-1:0]   target_next;
  logic              out_of_range;
  logic              taken;
  logic              halt_hit;
  logic              can_issue;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush_pulse;

  branch_target_calc #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_btc (
    .br_pc_i        (bus.br_pc),
    .imm_i          (bus.imm),
    .target_o       (target),
    .out_of_range_o (out_of_range)
  );

  assign taken       = bus.branch & bus.zero & ((state_q == ST_FETCH) | (state_q == ST_HALT));
  assign halt_hit    = (state_q == ST_FETCH) & ~bus.stall & req_valid_q
                       & (bus.imem_data[DATA_W-1 -: OPC_W] == HALT_OPCODE);
  assign can_issue   = pc_q < DEPTH_PC;
  assign target_next = {1'b0, target} + PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PCW;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      ins_q       <= '0;
      ins_pc_q    <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    ins_valid_d = ins_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          req_pc_d    = RESET_ADDR;
          pc_d        = RESET_NEXT;
          req_valid_d = 1'b1;
        end
      end
      ST_FETCH, ST_HALT: begin
        if (taken) begin
          ins_valid_d = 1'b0;
          if (out_of_range) begin
            state_d     = ST_FAULT;
            req_valid_d = 1'b0;
          end else begin
            state_d     = ST_FETCH;
            req_pc_d    = target;
            pc_d        = target_next;
            req_valid_d = 1'b1;
          end
        end else if (state_q == ST_HALT) begin
          if (!bus.stall) ins_valid_d = 1'b0;
          if (bus.start) begin
            state_d     = ST_FETCH;
            req_pc_d    = RESET_ADDR;
            pc_d        = RESET_NEXT;
            req_valid_d = 1'b1;
          end
        end else if (!bus.stall) begin
          ins_valid_d = req_valid_q;
          if (req_valid_q) begin
            ins_d    = bus.imem_data;
            ins_pc_d = req_pc_q;
          end
          if (halt_hit) begin
            state_d     = ST_HALT;
            req_valid_d = 1'b0;
          end else if (can_issue) begin
            req_pc_d    = pc_q[ADDR_W-1:0];
            pc_d        = pc_q + PC_W'(1);
            req_valid_d = 1'b1;
          end else begin
            req_valid_d = 1'b0;
          end
        end
      end
      default: ins_valid_d = 1'b0;
    endcase
  end

  // A stall re-reads the outstanding word so its data is still on imem_data at release.
  always_comb begin
    fetch_en    = 1'b0;
    fetch_addr  = '0;
    flush_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          fetch_en   = 1'b1;
          fetch_addr = RESET_ADDR;
        end
      end
      ST_FETCH, ST_HALT: begin
        if (taken) begin
          flush_pulse = 1'b1;
          if (!out_of_range) begin
            fetch_en   = 1'b1;
            fetch_addr = target;
          end
        end else if (state_q == ST_HALT) begin
          if (bus.start) begin
            fetch_en   = 1'b1;
            fetch_addr = RESET_ADDR;
          end
        end else if (bus.stall) begin
          if (req_valid_q) begin
            fetch_en   = 1'b1;
            fetch_addr = req_pc_q;
          end
        end else if (!halt_hit && can_issue) begin
          fetch_en   = 1'b1;
          fetch_addr = pc_q[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  assign bus.imem_en   = fetch_en;
  assign bus.imem_addr = fetch_addr;
  assign bus.flush     = flush_pulse;
  assign bus.ins       = ins_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.fault     = (state_q == ST_FAULT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural fetch model.
module tb_fetch_sequencer;
  localparam int DEPTH = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_W(20), .ADDR_W(5)) bus ();

  fetch_sequencer #(
    .DATA_W(20), .ADDR_W(5), .MEM_DEPTH(DEPTH), .RESET_PC(0), .HALT_OPCODE(4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [19:0] mem [0:31];
  logic [19:0] mem_q = '0;
  always @(posedge clk) if (bus.imem_en) mem_q <= mem[bus.imem_addr];
  assign bus.imem_data = mem_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  // Model: fetch mode, next fetch address, one outstanding read, one decode slot.
  typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mmode_e;
  mmode_e      m_mode;
  int          m_next, m_fly_a, m_dpc;
  bit          m_fly_v, m_dv;
  logic [19:0] m_dw;

  task automatic m_reset();
    m_mode = M_IDLE; m_next = 0; m_fly_v = 0; m_fly_a = 0;
    m_dv = 0; m_dw = '0; m_dpc = 0;
  endtask

  always @(negedge clk) begin : cmp
    logic [34:0] act, want;
    logic [19:0] ew, w;
    bit tk, oor, e_en, e_fl, ev, eh, ef;
    int tgt, e_addr, epc;
    if (rst) begin
      m_reset();
      chk("reset_outputs", {bus.ins_valid, bus.ins, bus.ins_pc, bus.imem_en, bus.imem_addr,
                            bus.flush, bus.halted, bus.fault}, '0);
    end else begin
      ev = m_dv; ew = m_dw; epc = m_dpc;
      eh = (m_mode == M_HALT); ef = (m_mode == M_FAULT);
      e_en = 0; e_addr = 0; e_fl = 0;
      tgt = int'(bus.br_pc) + 1 + int'($signed(bus.imm));
      oor = (tgt < 0) || (tgt >= DEPTH);
      tk  = bus.branch && bus.zero && (m_mode == M_RUN || m_mode == M_HALT);
      if (tk) begin
        e_fl = 1; m_dv = 0; m_fly_v = 0;
        if (oor) m_mode = M_FAULT;
        else begin
          e_en = 1; e_addr = tgt; m_fly_v = 1; m_fly_a = tgt; m_next = tgt + 1; m_mode = M_RUN;
        end
      end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
        if (m_mode == M_HALT && !bus.stall) m_dv = 0;
        if (bus.start) begin
          e_en = 1; e_addr = 0; m_fly_v = 1; m_fly_a = 0; m_next = 1; m_mode = M_RUN;
        end
      end else if (m_mode == M_RUN) begin
        if (bus.stall) begin
          e_en = m_fly_v; e_addr = m_fly_a;
        end else begin
          w = mem[m_fly_a];
          m_dv = m_fly_v;
          if (m_fly_v) begin m_dw = w; m_dpc = m_fly_a; end
          if (m_fly_v && w[19:16] == 4'hF) begin
            m_mode = M_HALT; m_fly_v = 0;
          end else if (m_next < DEPTH) begin
            e_en = 1; e_addr = m_next; m_fly_v = 1; m_fly_a = m_next; m_next++;
          end else m_fly_v = 0;
        end
      end
      act  = {bus.ins_valid, bus.ins_valid ? bus.ins : 20'h0, bus.ins_valid ? bus.ins_pc : 5'h0,
              bus.imem_en, bus.imem_en ? bus.imem_addr : 5'h0, bus.flush, bus.halted, bus.fault};
      want = {ev, ev ? ew : 20'h0, ev ? 5'(epc) : 5'h0,
              e_en, e_en ? 5'(e_addr) : 5'h0, e_fl, eh, ef};
      chk("cycle", act, want);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.start = 0; bus.stall = 0; bus.branch = 0; bus.zero = 0; bus.br_pc = '0; bus.imm = '0;
  endtask

  task automatic apply_reset(input bit scramble);
    @(posedge clk); #3;
    rst = 1'b1;
    drive_idle();
    #1 chk("async_reset", {bus.ins_valid, bus.ins, bus.ins_pc, bus.imem_en, bus.imem_addr,
                           bus.flush, bus.halted, bus.fault}, '0);
    if (scramble) for (int i = 0; i < 32; i++) mem[i] = 20'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic take_branch(input logic [4:0] pc, input logic [19:0] off);
    bus.branch = 1; bus.zero = 1; bus.br_pc = pc; bus.imm = off;
  endtask

  initial begin
    drive_idle();
    for (int i = 0; i < 32; i++) mem[i] = 20'h00100 + 20'(i);
    for (int i = 0; i < 4; i++) mem[i] = 20'(i + 1);
    mem[4] = 20'hF0000;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 chk("reset_idle", {bus.ins_valid, bus.halted, bus.fault, bus.imem_en, bus.flush}, '0);

    // Sequential fetch up to HALT at address 4
    tick(); bus.start = 1;
    #1 chk("start_issue", {bus.imem_en, bus.imem_addr}, {1'b1, 5'd0});
    tick(); bus.start = 0;
    tick();
    #1 chk("first_ins", {bus.ins_valid, bus.ins_pc, bus.ins}, {1'b1, 5'd0, 20'h00001});
    for (int k = 1; k <= 4; k++) begin
      tick();
      #1 chk("seq_ins", {bus.ins_valid, bus.ins_pc, bus.ins},
             {1'b1, 5'(k), (k == 4) ? 20'hF0000 : 20'(k + 1)});
    end
    chk("halt_state", {bus.halted, bus.imem_en}, {1'b1, 1'b0});

    // Stall three cycles while ins_pc=2
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    repeat (3) tick();
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1 chk("stall_hold", {bus.ins_valid, bus.ins_pc, bus.ins, bus.imem_en, bus.imem_addr},
             {1'b1, 5'd2, 20'h00003, 1'b1, 5'd3});
    end
    tick(); bus.stall = 0;
    tick();
    #1 chk("stall_release", {bus.ins_valid, bus.ins_pc, bus.ins}, {1'b1, 5'd3, 20'h00004});
    tick();
    #1 chk("stall_then_halt", {bus.ins_pc, bus.halted}, {5'd4, 1'b1});

    // Taken branch 2+1+5 = 8
    for (int i = 0; i < 32; i++) mem[i] = 20'h01000 + 20'(i);
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    repeat (2) tick();
    take_branch(5'd2, 20'd5);
    #1 chk("branch_issue", {bus.flush, bus.imem_en, bus.imem_addr}, {1'b1, 1'b1, 5'd8});
    tick(); drive_idle();
    #1 chk("branch_squash", {bus.ins_valid, bus.flush}, {1'b0, 1'b0});
    tick();
    #1 chk("branch_target_ins", {bus.ins_valid, bus.ins_pc, bus.ins}, {1'b1, 5'd8, 20'h01008});

    // Branch priority over stall and over HALT capture (target 1+1-2 = 0)
    mem[5] = 20'hF0000;
    tick(); take_branch(5'd1, 20'hFFFFE);
    tick(); drive_idle();
    repeat (5) tick();
    bus.stall = 1; take_branch(5'd1, 20'hFFFFE);
    #1 chk("prio_stall", {bus.flush, bus.imem_en, bus.imem_addr}, {1'b1, 1'b1, 5'd0});
    tick(); drive_idle();
    #1 chk("prio_stall_after", {bus.halted, bus.ins_valid}, {1'b0, 1'b0});
    repeat (5) tick();
    take_branch(5'd1, 20'hFFFFE);
    #1 chk("prio_halt", {bus.flush, bus.imem_en, bus.imem_addr}, {1'b1, 1'b1, 5'd0});
    tick(); drive_idle();
    #1 chk("prio_halt_after", bus.halted, 1'b0);
    repeat (6) tick();
    #1 chk("prio_then_halt", {bus.halted, bus.ins_pc, bus.ins}, {1'b1, 5'd5, 20'hF0000});

    // Out-of-range branch: 10+1+20 = 31
    mem[5] = 20'h01005;
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    tick(); take_branch(5'd10, 20'd20);
    #1 chk("fault_cycle", {bus.flush, bus.imem_en}, {1'b1, 1'b0});
    tick(); drive_idle();
    #1 chk("fault_set", {bus.fault, bus.imem_en, bus.ins_valid, bus.halted}, {1'b1, 1'b0, 1'b0, 1'b0});
    tick(); bus.start = 1;
    #1 chk("fault_ignores_start", bus.imem_en, 1'b0);
    tick(); bus.start = 0;
    #1 chk("fault_sticky", bus.fault, 1'b1);
    apply_reset(0);
    #1 chk("fault_cleared", bus.fault, 1'b0);

    // Run off the end of memory, then async reset mid-fetch
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    repeat (19) tick();
    #1 chk("end_of_mem_en", {bus.imem_en, bus.fault}, {1'b0, 1'b0});
    tick();
    #1 chk("end_last_ins", {bus.ins_valid, bus.ins_pc}, {1'b1, 5'd19});
    tick();
    #1 chk("end_drained", {bus.ins_valid, bus.imem_en, bus.fault}, {1'b0, 1'b0, 1'b0});
    tick(); bus.start = 1;
    tick(); bus.start = 0;
    repeat (3) tick();
    apply_reset(1);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int off;
      tick();
      if ((m_mode == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        apply_reset(1);
        continue;
      end
      off        = int'($urandom_range(0, 30)) - 12;
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.stall  = ($urandom_range(0, 9) < 3);
      bus.branch = ($urandom_range(0, 5) == 0);
      bus.zero   = 1'($urandom_range(0, 1));
      bus.br_pc  = 5'($urandom_range(0, 21));
      bus.imm    = 20'(off);
    end

    tick(); drive_idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
